matrix_mult_nxn_seq: RTL and testbench

Parametrised sequential N×N matrix multiplier computing C = A·B over flattened row-major operand buses, with configurable element width, accumulator width and signed/unsigned mode. It is the next generation of the team's fixed 10×10 multiplier and differs from it in four ways:
- operands are latched at start;
- one multiply-accumulate is issued per clock through a two-stage MAC pipeline;
- result elements are full width, with no truncation;
- a busy/done handshake is provided.

It sits behind the DSD control path as the matrix-arithmetic engine.

---
 rtl/mm_pkg.sv | 21 ++
 rtl/matrix_mult_nxn_seq_if.sv | 18 +
 rtl/mm_mac_pipe.sv | 83 ++++++++
 rtl/matrix_mult_nxn_seq.sv | 142 ++++++++++++++
 tb/tb_matrix_mult_nxn_seq.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the sequential N x N matrix multiplier: state encoding
// and the width helpers used by the top level and its interface.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Width of one matrix index (i, j or k); never narrower than one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Result width that can hold a full N-term dot product without wrapping.
  function automatic int default_aw(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mult_nxn_seq_if.sv
// Operand/result bus and busy/done handshake of the matrix multiplier.
interface matrix_mult_nxn_seq_if #(
  parameter int N  = 10,
  parameter int DW = 8,
  parameter int AW = mm_pkg::default_aw(DW, N)
) ();

  logic              start;
  logic [N*N*DW-1:0] A;
  logic [N*N*DW-1:0] B;
  logic [N*N*AW-1:0] C;
  logic              busy;
  logic              done;

  modport master (output start, A, B, input C, busy, done);
  modport slave  (input start, A, B, output C, busy, done);

endinterface

// File: rtl/mm_mac_pipe.sv
// Two-stage multiply-accumulate pipeline; the k-first/k-last flags and the
// destination index travel alongside each product.
module mm_mac_pipe #(
  parameter int DW     = 8,
  parameter int AW     = 20,
  parameter int SIGNED = 0,
  parameter int XW     = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [XW-1:0] in_idx,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          wr_en,
  output logic [XW-1:0] wr_idx,
  output logic [AW-1:0] wr_data
);

  localparam int PW = 2 * DW;

  logic          sign_a;
  logic          sign_b;
  logic          sign_p;
  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;
  logic [PW-1:0] p;
  logic          p_valid;
  logic          p_first;
  logic          p_last;
  logic [XW-1:0] p_idx;
  logic [AW-1:0] p_ext;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;

  // Widening both operands to 2*DW first makes the low 2*DW product bits
  // correct for two's complement as well as unsigned operands.
  assign sign_a = (SIGNED != 0) && a[DW-1];
  assign sign_b = (SIGNED != 0) && b[DW-1];
  assign a_x    = {{DW{sign_a}}, a};
  assign b_x    = {{DW{sign_b}}, b};
  assign sign_p = (SIGNED != 0) && p[PW-1];

  generate
    if (AW > PW) begin : g_extend
      assign p_ext = {{(AW-PW){sign_p}}, p};
    end else begin : g_wrap
      assign p_ext = p[AW-1:0];
    end
  endgenerate

  assign sum = p_first ? p_ext : acc + p_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      p       <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      p_idx   <= '0;
      acc     <= '0;
    end else begin
      p_valid <= in_valid;
      if (in_valid) begin
        p       <= a_x * b_x;
        p_first <= in_first;
        p_last  <= in_last;
        p_idx   <= in_idx;
      end
      if (p_valid) begin
        acc <= sum;
      end
    end
  end

  // The completed dot product is handed out in the same cycle the last term is added.
  assign wr_en   = p_valid & p_last;
  assign wr_idx  = p_idx;
  assign wr_data = sum;

endmodule

// File: rtl/matrix_mult_nxn_seq.sv
// Sequential N x N matrix multiplier C = A*B: operands latched at start, one
// multiply-accumulate per clock, full-width results and a busy/done handshake.
module matrix_mult_nxn_seq
  import mm_pkg::*;
#(
  parameter int N      = 10,
  parameter int DW     = 8,
  parameter int AW     = default_aw(DW, N),
  parameter int SIGNED = 0
) (
  input logic                 clk,
  input logic                 reset,
  matrix_mult_nxn_seq_if.slave bus
);

  localparam int            IW   = index_width(N);
  localparam int            NE   = N * N;
  localparam int            XW   = $clog2(NE);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state;
  logic [IW-1:0]    i;
  logic [IW-1:0]    j;
  logic [IW-1:0]    k;
  logic             busy_r;
  logic             done_r;
  logic [DW-1:0]    a_in [NE];
  logic [DW-1:0]    b_in [NE];
  logic [DW-1:0]    a_op [NE];
  logic [DW-1:0]    b_op [NE];
  logic [AW-1:0]    c_mem [NE];
  logic [NE*AW-1:0] c_flat;
  logic [XW-1:0]    a_sel;
  logic [XW-1:0]    b_sel;
  logic [XW-1:0]    c_sel;
  logic             issue;
  logic             wr_en;
  logic [XW-1:0]    wr_idx;
  logic [AW-1:0]    wr_data;

  genvar g;
  generate
    for (g = 0; g < NE; g++) begin : g_unpack
      assign a_in[g]             = bus.A[g*DW +: DW];
      assign b_in[g]             = bus.B[g*DW +: DW];
      assign c_flat[g*AW +: AW]  = c_mem[g];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_r <= 1'b1;
            i      <= '0;
            j      <= '0;
            k      <= '0;
          end
        end
        RUN: begin
          if (k == LAST) begin
            k <= '0;
            if (j == LAST) begin
              j <= '0;
              if (i == LAST) begin
                i     <= '0;
                state <= DRAIN;
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Products are taken only from these copies, so A and B may change after start.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      a_op <= a_in;
      b_op <= b_in;
    end
  end

  assign issue = (state == RUN);
  assign a_sel = XW'(int'(i) * N + int'(k));
  assign b_sel = XW'(int'(k) * N + int'(j));
  assign c_sel = XW'(int'(i) * N + int'(j));

  mm_mac_pipe #(
    .DW     (DW),
    .AW     (AW),
    .SIGNED (SIGNED),
    .XW     (XW)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .in_valid (issue),
    .in_first (k == '0),
    .in_last  (k == LAST),
    .in_idx   (c_sel),
    .a        (a_op[a_sel]),
    .b        (b_op[b_sel]),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      c_mem <= '{default: '0};
    end else if (wr_en) begin
      c_mem[wr_idx] <= wr_data;
    end
  end

  assign bus.C    = c_flat;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_matrix_mult_nxn_seq.sv
// Scoreboard bench for matrix_mult_nxn_seq: two unsigned/signed 2x2 instances
// and one 10x10 instance, with expected results queued at start time.
module tb_matrix_mult_nxn_seq;

  typedef struct {
    logic [2047:0] c;
    int            edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  matrix_mult_nxn_seq_if #(.N(2),  .DW(8), .AW(17)) if0 ();
  matrix_mult_nxn_seq_if #(.N(10), .DW(8))          if1 ();
  matrix_mult_nxn_seq_if #(.N(2),  .DW(8), .AW(17)) if2 ();

  matrix_mult_nxn_seq #(.N(2),  .DW(8), .AW(17), .SIGNED(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  matrix_mult_nxn_seq #(.N(10), .DW(8),          .SIGNED(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  matrix_mult_nxn_seq #(.N(2),  .DW(8), .AW(17), .SIGNED(1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic [2047:0] pack_op2(input int a00, input int a01, input int a10, input int a11);
    logic [2047:0] r;
    r = '0;
    r[0  +: 8] = 8'(a00);
    r[8  +: 8] = 8'(a01);
    r[16 +: 8] = 8'(a10);
    r[24 +: 8] = 8'(a11);
    return r;
  endfunction

  function automatic logic [2047:0] pack_c2(input int c00, input int c01, input int c10, input int c11);
    logic [2047:0] r;
    r = '0;
    r[0  +: 17] = 17'(c00);
    r[17 +: 17] = 17'(c01);
    r[34 +: 17] = 17'(c10);
    r[51 +: 17] = 17'(c11);
    return r;
  endfunction

  // Drives operands and start on the selected instance; the caller drops start.
  task automatic applyStimulus(input int dut, input logic [2047:0] a, input logic [2047:0] b,
                               input logic [2047:0] exp_c, input bit expect_done);
    exp_t ent;
    ent.c       = exp_c;
    ent.edge_no = edge_cnt + 1 + ((dut == 1) ? 1001 : 9);
    case (dut)
      0: begin if0.A = a[31:0];  if0.B = b[31:0];  if0.start = 1'b1; if (expect_done) q0.push_back(ent); end
      1: begin if1.A = a[799:0]; if1.B = b[799:0]; if1.start = 1'b1; if (expect_done) q1.push_back(ent); end
      default: begin if2.A = a[31:0]; if2.B = b[31:0]; if2.start = 1'b1; if (expect_done) q2.push_back(ent); end
    endcase
  endtask

  always @(negedge clk) begin
    exp_t ent;
    if (if0.done === 1'b1) begin
      if (q0.size() == 0) begin
        checkOutput("dut0_unexpected_done", 64'(if0.done), 64'd0);
      end else begin
        ent = q0.pop_front();
        checkOutput("dut0_done_edge", 64'(edge_cnt), 64'(ent.edge_no));
        for (int x = 0; x < 4; x++)
          checkOutput($sformatf("dut0_C[%0d]", x), 64'(if0.C[x*17 +: 17]), 64'(ent.c[x*17 +: 17]));
      end
    end
  end

  always @(negedge clk) begin
    exp_t ent;
    if (if1.done === 1'b1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1_unexpected_done", 64'(if1.done), 64'd0);
      end else begin
        ent = q1.pop_front();
        checkOutput("dut1_done_edge", 64'(edge_cnt), 64'(ent.edge_no));
        for (int x = 0; x < 100; x++)
          checkOutput($sformatf("dut1_C[%0d]", x), 64'(if1.C[x*20 +: 20]), 64'(ent.c[x*20 +: 20]));
      end
    end
  end

  always @(negedge clk) begin
    exp_t ent;
    if (if2.done === 1'b1) begin
      if (q2.size() == 0) begin
        checkOutput("dut2_unexpected_done", 64'(if2.done), 64'd0);
      end else begin
        ent = q2.pop_front();
        checkOutput("dut2_done_edge", 64'(edge_cnt), 64'(ent.edge_no));
        for (int x = 0; x < 4; x++)
          checkOutput($sformatf("dut2_C[%0d]", x), 64'(if2.C[x*17 +: 17]), 64'(ent.c[x*17 +: 17]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2047:0] all_ones;
    logic [2047:0] exp10;

    reset     = 1'b1;
    if0.start = 1'b0; if0.A = '0; if0.B = '0;
    if1.start = 1'b0; if1.A = '0; if1.B = '0;
    if2.start = 1'b0; if2.A = '0; if2.B = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_dut0_busy", 64'(if0.busy), 64'd0);
    checkOutput("rst_dut0_done", 64'(if0.done), 64'd0);
    checkOutput("rst_dut0_C",    64'(if0.C),    64'd0);
    checkOutput("rst_dut1_busy", 64'(if1.busy), 64'd0);
    checkOutput("rst_dut1_done", 64'(if1.done), 64'd0);
    for (int x = 0; x < 100; x++)
      checkOutput($sformatf("rst_dut1_C[%0d]", x), 64'(if1.C[x*20 +: 20]), 64'd0);
    checkOutput("rst_dut2_busy", 64'(if2.busy), 64'd0);
    checkOutput("rst_dut2_C",    64'(if2.C),    64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic 2x2 unsigned product");
    applyStimulus(0, pack_op2(1, 2, 3, 4), pack_op2(5, 6, 7, 8), pack_c2(19, 22, 43, 50), 1'b1);
    @(negedge clk);
    if0.start = 1'b0;
    checkOutput("t1_busy_e0", 64'(if0.busy), 64'd1);
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_busy_e%0d", e), 64'(if0.busy), (e <= 8) ? 64'd1 : 64'd0);
    end
    repeat (3) @(negedge clk);

    $display("[TB] operand independence and ignored start");
    applyStimulus(0, pack_op2(2, 0, 1, 3), pack_op2(4, 5, 6, 7), pack_c2(8, 10, 22, 26), 1'b1);
    @(negedge clk);
    if0.start = 1'b0;
    if0.A     = '0;
    if0.B     = '0;
    repeat (2) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (15) @(negedge clk);

    $display("[TB] back-to-back runs");
    applyStimulus(0, pack_op2(3, 1, 2, 5), pack_op2(1, 4, 2, 0), pack_c2(5, 12, 12, 8), 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(0, pack_op2(0, 1, 2, 0), pack_op2(9, 8, 7, 6), pack_c2(7, 6, 18, 16), 1'b1);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (15) @(negedge clk);

    $display("[TB] reset in the middle of a run");
    applyStimulus(0, pack_op2(1, 2, 3, 4), pack_op2(5, 6, 7, 8), '0, 1'b0);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_busy", 64'(if0.busy), 64'd0);
    checkOutput("mid_rst_done", 64'(if0.done), 64'd0);
    for (int x = 0; x < 4; x++)
      checkOutput($sformatf("mid_rst_C[%0d]", x), 64'(if0.C[x*17 +: 17]), 64'd0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("post_rst_busy", 64'(if0.busy), 64'd0);

    $display("[TB] signed 2x2 products");
    applyStimulus(2, pack_op2(-128, 1, -1, 127), pack_op2(-128, -1, 2, 127),
                  pack_c2(16386, 255, 382, 16130), 1'b1);
    @(negedge clk);
    if2.start = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus(2, pack_op2(-1, 0, 0, -1), pack_op2(3, -4, 5, 6), pack_c2(-3, 4, -5, -6), 1'b1);
    @(negedge clk);
    if2.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] 10x10 all-255 operands");
    all_ones = '1;
    exp10    = '0;
    for (int x = 0; x < 100; x++) exp10[x*20 +: 20] = 20'd650250;
    applyStimulus(1, all_ones, all_ones, exp10, 1'b1);
    @(negedge clk);
    if1.start = 1'b0;
    repeat (1010) @(negedge clk);

    checkOutput("q0_pending", 64'(q0.size()), 64'd0);
    checkOutput("q1_pending", 64'(q1.size()), 64'd0);
    checkOutput("q2_pending", 64'(q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
